ahb2apb_mslave: RTL and testbench

Parametrised AHB-Lite to APB bridge; successor to the fixed single-slave `ahb2apb`. Sits between the AHB interconnect and a cluster of `NSLV` APB peripherals:
- converts each accepted AHB NONSEQ/SEQ transfer into one APB SETUP/ACCESS pair;
- decodes the target peripheral from the address;
- honours `PREADY` wait states;
- maps `PSLVERR`, decode misses and `PREADY` timeouts onto a two-cycle AHB ERROR response.

---
 rtl/ahb2apb_pkg.sv | 29 ++
 rtl/apb_slave_mux.sv | 44 ++++
 rtl/ahb2apb_mslave.sv | 156 +++++++++++++++
 tb/tb_ahb2apb_mslave.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb2apb_pkg.sv
// Shared types and encodings for the AHB-Lite to multi-slave APB bridge.
package ahb2apb_pkg;

    // Bridge FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WWAIT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB response codes
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Width of the slave-index field; a single slave still needs one bit
    function automatic int slv_width(input int nslv);
        return (nslv > 1) ? $clog2(nslv) : 1;
    endfunction

endpackage

// File: rtl/apb_slave_mux.sv
// Combinational APB slave decode: one-hot select plus return-path mux.
module apb_slave_mux
    import ahb2apb_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NSLV = 4,
    parameter int SW   = slv_width(NSLV)
) (
    input  logic [SW-1:0]      idx,
    input  logic [NSLV*DW-1:0] prdata,
    input  logic [NSLV-1:0]    pready,
    input  logic [NSLV-1:0]    pslverr,
    output logic [NSLV-1:0]    psel_mask,
    output logic [DW-1:0]      sel_prdata,
    output logic               sel_pready,
    output logic               sel_pslverr,
    output logic               decode_err
);

    // Indices past the populated slaves select nothing
    assign decode_err = (32'(idx) >= 32'(NSLV));

    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_sel
            assign psel_mask[gi] = (32'(idx) == 32'(gi));
        end
    endgenerate

    // AND-OR return mux driven by the one-hot mask, so a bad index reads as zero
    always_comb begin
        sel_prdata  = '0;
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (psel_mask[i]) begin
                sel_prdata  = sel_prdata | prdata[i*DW +: DW];
                sel_pready  = sel_pready | pready[i];
                sel_pslverr = sel_pslverr | pslverr[i];
            end
        end
    end

endmodule

// File: rtl/ahb2apb_mslave.sv
// AHB-Lite to APB bridge serving NSLV peripherals decoded from HADDR.
module ahb2apb_mslave
    import ahb2apb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int NSLV    = 4,
    parameter int SLV_LSB = 12,
    parameter int TIMEOUT = 0
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSELAPB,
    input  logic [AW-1:0]      HADDR,
    input  logic               HWRITE,
    input  logic [1:0]         HTRANS,
    input  logic [DW-1:0]      HWDATA,
    output logic [DW-1:0]      HRDATA,
    output logic               HREADY,
    output logic               HRESP,
    input  logic [NSLV*DW-1:0] PRDATA,
    input  logic [NSLV-1:0]    PREADY,
    input  logic [NSLV-1:0]    PSLVERR,
    output logic [NSLV-1:0]    PSEL,
    output logic               PENABLE,
    output logic [AW-1:0]      PADDR,
    output logic               PWRITE,
    output logic [DW-1:0]      PWDATA
);

    localparam int SW = slv_width(NSLV);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t          state_reg;
    state_t          accept_state;
    logic [AW-1:0]   paddr_reg;
    logic            pwrite_reg;
    logic [DW-1:0]   pwdata_reg;
    logic [SW-1:0]   idx_reg;
    logic [TW-1:0]   tcnt_reg;

    logic [NSLV-1:0] psel_mask;
    logic [DW-1:0]   sel_prdata;
    logic            sel_pready;
    logic            sel_pslverr;
    logic            decode_err;

    logic            hready_int;
    logic            active_xfer;
    logic            accept;
    logic            addr_miss;
    logic            timeout_hit;

    apb_slave_mux #(
        .DW   (DW),
        .NSLV (NSLV),
        .SW   (SW)
    ) u_mux (
        .idx         (idx_reg),
        .prdata      (PRDATA),
        .pready      (PREADY),
        .pslverr     (PSLVERR),
        .psel_mask   (psel_mask),
        .sel_prdata  (sel_prdata),
        .sel_pready  (sel_pready),
        .sel_pslverr (sel_pslverr),
        .decode_err  (decode_err)
    );

    // The whole upper address field is checked, so aliases above the populated slaves miss
    assign addr_miss   = (HADDR >> SLV_LSB) >= AW'(NSLV);
    assign active_xfer = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign accept      = HSELAPB & active_xfer & hready_int;
    assign timeout_hit = (TIMEOUT > 0) && !sel_pready
                         && ((32'(tcnt_reg) + 32'd1) == 32'(TIMEOUT));

    // Ready: free in IDLE/ERR2, follows the selected slave in ACCESS, stalled otherwise
    always_comb begin
        hready_int = 1'b0;
        case (state_reg)
            ST_IDLE, ST_ERR2: hready_int = 1'b1;
            ST_ACCESS:        hready_int = sel_pready & ~sel_pslverr;
            default:          hready_int = 1'b0;
        endcase
    end

    // Where a freshly accepted transfer goes: misses skip APB entirely
    always_comb begin
        if (addr_miss)
            accept_state = ST_ERR1;
        else if (HWRITE)
            accept_state = ST_WWAIT;
        else
            accept_state = ST_SETUP;
    end

    // FSM, APB address/data registers and ACCESS timeout counter
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg  <= ST_IDLE;
            paddr_reg  <= '0;
            pwrite_reg <= 1'b0;
            pwdata_reg <= '0;
            idx_reg    <= '0;
            tcnt_reg   <= '0;
        end else begin
            if (accept) begin
                paddr_reg  <= HADDR;
                pwrite_reg <= HWRITE;
                idx_reg    <= HADDR[SLV_LSB +: SW];
            end
            case (state_reg)
                ST_IDLE, ST_ERR2: begin
                    state_reg <= accept ? accept_state : ST_IDLE;
                end
                ST_WWAIT: begin
                    // HWDATA is only valid in the AHB data phase, one cycle after accept
                    pwdata_reg <= HWDATA;
                    state_reg  <= ST_SETUP;
                end
                ST_SETUP: begin
                    tcnt_reg  <= '0;
                    state_reg <= decode_err ? ST_ERR1 : ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (sel_pready) begin
                        if (sel_pslverr)
                            state_reg <= ST_ERR1;
                        else
                            state_reg <= accept ? accept_state : ST_IDLE;
                    end else begin
                        tcnt_reg <= tcnt_reg + 1'b1;
                        if (timeout_hit)
                            state_reg <= ST_ERR1;
                    end
                end
                ST_ERR1: begin
                    state_reg <= ST_ERR2;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign HREADY  = hready_int;
    assign HRESP   = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA  = (state_reg == ST_ACCESS) ? sel_prdata : '0;
    assign PSEL    = ((state_reg == ST_SETUP) || (state_reg == ST_ACCESS)) ? psel_mask : '0;
    assign PENABLE = (state_reg == ST_ACCESS);
    assign PADDR   = paddr_reg;
    assign PWRITE  = pwrite_reg;
    assign PWDATA  = pwdata_reg;

endmodule

// File: tb/tb_ahb2apb_mslave.sv
// Scoreboard bench for ahb2apb_mslave: pipelined AHB master, parametrised APB slave model.
module tb_ahb2apb_mslave;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NSLV = 4;
    localparam int TMO  = 8;

    logic               HCLK = 1'b0;
    logic               HRESET;
    logic               HSELAPB;
    logic [AW-1:0]      HADDR;
    logic               HWRITE;
    logic [1:0]         HTRANS;
    logic [DW-1:0]      HWDATA;
    logic [DW-1:0]      HRDATA;
    logic               HREADY;
    logic               HRESP;
    logic [NSLV*DW-1:0] PRDATA;
    logic [NSLV-1:0]    PREADY;
    logic [NSLV-1:0]    PSLVERR;
    logic [NSLV-1:0]    PSEL;
    logic               PENABLE;
    logic [AW-1:0]      PADDR;
    logic               PWRITE;
    logic [DW-1:0]      PWDATA;

    always #5 HCLK = ~HCLK;

    ahb2apb_mslave #(
        .AW(AW), .DW(DW), .NSLV(NSLV), .SLV_LSB(12), .TIMEOUT(TMO)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELAPB(HSELAPB), .HADDR(HADDR),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA)
    );

    // ---------------- APB slave model ----------------
    int              ws_cfg;
    logic            stuck;
    logic [NSLV-1:0] err_mask;
    int              acc_cnt = 0;

    function automatic logic [31:0] slave_rdata(input logic [31:0] a);
        case (a)
            32'h0000_0020: return 32'h0000_0010;
            32'h0000_0000: return 32'hFFFF_FFFF;
            32'h0000_1000: return 32'hFFFF_FFFB;
            32'h0000_1100: return 32'hFFFF_FFF8;
            32'h0000_0100: return 32'hFFFF_FFF4;
            default:       return 32'hA500_0000 ^ a;
        endcase
    endfunction

    // Only the addressed slave returns clean data; the others return a tainted word
    always_comb begin
        PRDATA = '0;
        for (int i = 0; i < NSLV; i++)
            PRDATA[i*DW +: DW] = slave_rdata(PADDR)
                                 ^ ((int'(PADDR >> 12) == i) ? 32'h0 : 32'hDEAD_0000);
    end

    assign PREADY  = (!stuck && acc_cnt >= ws_cfg) ? '1 : '0;
    assign PSLVERR = err_mask;

    always @(posedge HCLK) begin
        if (PENABLE && !(|(PSEL & PREADY)))
            acc_cnt <= acc_cnt + 1;
        else
            acc_cnt <= 0;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [1:0]  trans;
    } cmd_t;

    typedef struct {
        logic [31:0]     addr;
        logic            wr;
        logic [31:0]     wdata;
        logic [31:0]     rdata;
        logic            resp;
        int              waits;
        logic [NSLV-1:0] pmask;
        int              pcyc;
        int              rcyc;
    } exp_t;

    cmd_t cmd_q[$];
    exp_t exp_q[$];

    // Expected outcome of one transfer from the current slave-model settings
    function automatic exp_t model(input cmd_t c);
        exp_t e;
        int   idx;
        int   wx;
        idx     = int'(c.addr >> 12);
        wx      = c.wr ? 1 : 0;
        e.addr  = c.addr;
        e.wr    = c.wr;
        e.wdata = c.wdata;
        e.rdata = 32'h0;
        e.resp  = 1'b0;
        e.pmask = '0;
        e.pcyc  = 0;
        e.rcyc  = 0;
        e.waits = 0;
        if (idx >= NSLV) begin
            e.resp = 1'b1; e.waits = 1; e.rcyc = 2;
        end else if (stuck) begin
            e.resp  = 1'b1;
            e.pmask = NSLV'(1 << idx);
            e.pcyc  = 1 + TMO;
            e.waits = wx + 1 + TMO + 1;
            e.rcyc  = 2;
        end else if (err_mask[idx]) begin
            e.resp  = 1'b1;
            e.pmask = NSLV'(1 << idx);
            e.pcyc  = 2 + ws_cfg;
            e.waits = wx + 1 + ws_cfg + 1 + 1;
            e.rcyc  = 2;
        end else begin
            e.pmask = NSLV'(1 << idx);
            e.pcyc  = 2 + ws_cfg;
            e.waits = wx + 1 + ws_cfg;
            e.rdata = slave_rdata(c.addr);
        end
        return e;
    endfunction

    // Pipelined AHB master: call and return at posedge+1
    task automatic run_cmds();
        cmd_t            cur;
        exp_t            e;
        logic            dvalid = 1'b0;
        int              waits = 0;
        int              pcyc = 0;
        int              rcyc = 0;
        logic [NSLV-1:0] pmask = '0;
        int              guard = 0;
        cur = '{addr: 32'h0, wr: 1'b0, wdata: 32'h0, trans: 2'b00};
        while ((cmd_q.size() > 0 || dvalid) && guard < 300) begin
            guard++;
            if (cmd_q.size() > 0) begin
                HSELAPB = 1'b1;
                HTRANS  = cmd_q[0].trans;
                HADDR   = cmd_q[0].addr;
                HWRITE  = cmd_q[0].wr;
            end else begin
                HSELAPB = 1'b0;
                HTRANS  = 2'b00;
            end
            HWDATA = dvalid ? cur.wdata : 32'h0;
            @(negedge HCLK);
            if (dvalid) begin
                if (PSEL != '0) begin pmask = pmask | PSEL; pcyc++; end
                if (HRESP) rcyc++;
                if (!HREADY) begin
                    waits++;
                end else begin
                    e = exp_q.pop_front();
                    $display("xfer %s addr=0x%08h resp=%0d hrdata=0x%08h waits=%0d psel=%b",
                             e.wr ? "WR" : "RD", e.addr, HRESP, HRDATA, waits, pmask);
                    check_val("hresp",  HRESP, e.resp);
                    check_val("waits",  waits, e.waits);
                    check_val("psel",   pmask, e.pmask);
                    check_val("pcyc",   pcyc,  e.pcyc);
                    check_val("rcyc",   rcyc,  e.rcyc);
                    check_val("paddr",  PADDR, e.addr);
                    check_val("pwrite", PWRITE, e.wr);
                    if (!e.wr)
                        check_val("hrdata", HRDATA, e.rdata);
                    else if (!e.resp)
                        check_val("pwdata", PWDATA, e.wdata);
                    dvalid = 1'b0;
                end
            end
            if (HREADY && cmd_q.size() > 0) begin
                cur = cmd_q.pop_front();
                exp_q.push_back(model(cur));
                dvalid = 1'b1;
                waits = 0; pcyc = 0; rcyc = 0; pmask = '0;
            end
            @(posedge HCLK);
            #1;
        end
        HSELAPB = 1'b0;
        HTRANS  = 2'b00;
        if (cmd_q.size() > 0 || dvalid)
            check_val("cycle_budget", 1, 0);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_psel"},    PSEL,    0);
        check_val({pfx, "_penable"}, PENABLE, 0);
        check_val({pfx, "_paddr"},   PADDR,   0);
        check_val({pfx, "_pwrite"},  PWRITE,  0);
        check_val({pfx, "_pwdata"},  PWDATA,  0);
        check_val({pfx, "_hready"},  HREADY,  1);
        check_val({pfx, "_hresp"},   HRESP,   0);
        check_val({pfx, "_hrdata"},  HRDATA,  0);
    endtask

    logic       idle_sel[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] idle_trans[4] = '{2'b10, 2'b00, 2'b01, 2'b11};

    initial begin
        HRESET = 1'b1; HSELAPB = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
        HWDATA = '0; ws_cfg = 0; stuck = 1'b0; err_mask = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check_reset_vals("reset");
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // unselected / IDLE / BUSY must not start anything
        for (int k = 0; k < 4; k++) begin
            HSELAPB = idle_sel[k];
            HTRANS  = idle_trans[k];
            HADDR   = 32'h0000_1004;
            HWRITE  = 1'b0;
            @(posedge HCLK);
            @(negedge HCLK);
            check_val("noxfer_psel",   PSEL,   0);
            check_val("noxfer_hready", HREADY, 1);
            check_val("noxfer_hresp",  HRESP,  0);
            @(posedge HCLK); #1;
        end
        HSELAPB = 1'b0; HTRANS = 2'b00;

        // single read, slave 0
        cmd_q.push_back('{addr: 32'h20, wr: 1'b0, wdata: 32'h0, trans: 2'b10});
        run_cmds();

        // write to slave 2 with two wait states
        ws_cfg = 2;
        cmd_q.push_back('{addr: 32'h2000, wr: 1'b1, wdata: 32'hFF, trans: 2'b10});
        run_cmds();

        // burst read slaves 0/1/1/0, zero wait states
        ws_cfg = 0;
        cmd_q.push_back('{addr: 32'h0000, wr: 1'b0, wdata: 32'h0, trans: 2'b10});
        cmd_q.push_back('{addr: 32'h1000, wr: 1'b0, wdata: 32'h0, trans: 2'b11});
        cmd_q.push_back('{addr: 32'h1100, wr: 1'b0, wdata: 32'h0, trans: 2'b11});
        cmd_q.push_back('{addr: 32'h0100, wr: 1'b0, wdata: 32'h0, trans: 2'b11});
        run_cmds();

        // mixed back-to-back read then write, one wait state
        ws_cfg = 1;
        cmd_q.push_back('{addr: 32'h3008, wr: 1'b0, wdata: 32'h0, trans: 2'b10});
        cmd_q.push_back('{addr: 32'h1010, wr: 1'b1, wdata: 32'h1234_5678, trans: 2'b10});
        run_cmds();

        // slave error on slave 1
        ws_cfg = 0;
        err_mask = 4'b0010;
        cmd_q.push_back('{addr: 32'h1000, wr: 1'b0, wdata: 32'h0, trans: 2'b10});
        run_cmds();
        err_mask = '0;

        // decode miss
        cmd_q.push_back('{addr: 32'h7000, wr: 1'b0, wdata: 32'h0, trans: 2'b10});
        run_cmds();

        // PREADY stuck low -> timeout
        stuck = 1'b1;
        cmd_q.push_back('{addr: 32'h3004, wr: 1'b0, wdata: 32'h0, trans: 2'b10});
        run_cmds();

        // reset in the middle of ACCESS
        HSELAPB = 1'b1; HTRANS = 2'b10; HADDR = 32'h1040; HWRITE = 1'b0;
        @(posedge HCLK); #1;
        HSELAPB = 1'b0; HTRANS = 2'b00;
        @(posedge HCLK);
        @(posedge HCLK);
        @(negedge HCLK);
        check_val("rstmid_penable", PENABLE, 1);
        HRESET = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        check_reset_vals("rstmid");
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        stuck = 1'b0;
        cmd_q.push_back('{addr: 32'h20, wr: 1'b0, wdata: 32'h0, trans: 2'b10});
        run_cmds();

        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
